// File: rtl/wbq_pkg.sv
// rtl/wbq_pkg.sv - shared entry type, constants and pointer helper for wb_queue
package wbq_pkg;

    localparam int WB_XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/wbq_fwd_lookup.sv
// rtl/wbq_fwd_lookup.sv - youngest-match forwarding scan over the queued entries
module wbq_fwd_lookup
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = WB_XLEN
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [4:0]                 address,
    output logic                       hit,
    output logic [XLEN-1:0]            data
);

    localparam int PTR_W = $clog2(DEPTH);

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count
                && entries[head + PTR_W'(i)].valid
                && entries[head + PTR_W'(i)].rd == address
                && address != REG_ZERO) begin
                hit  = 1'b1;
                data = entries[head + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - writeback queue feeding the register file write port; WBQ_BYPASS_EN enables empty-queue bypass
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = WB_XLEN
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic                     drain_en,
    output logic                     write_enable,
    output logic [4:0]               rd_address,
    output logic [XLEN-1:0]          rd_data,
    input  logic [4:0]               rs1_address,
    output logic                     rs1_fwd_hit,
    output logic [XLEN-1:0]          rs1_fwd_data,
    input  logic [4:0]               rs2_address,
    output logic                     rs2_fwd_hit,
    output logic [XLEN-1:0]          rs2_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        entries [DEPTH];
    wb_entry_t        head_entry;
    logic [PTR_W-1:0] head, tail;
    logic             empty, full, pop, space;
    logic             acc_mem, acc_alu, push, bypass, enqueue;
    logic [4:0]       in_rd;
    logic [XLEN-1:0]  in_data;
    logic             q1_hit, q2_hit;
    logic [XLEN-1:0]  q1_data, q2_data;

    assign empty      = (count == '0);
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign pop        = !empty && drain_en;
    assign space      = !full || pop;
    assign mem_ready  = space;
    assign alu_ready  = space && !mem_valid;
    assign acc_mem    = mem_valid && space;
    assign acc_alu    = alu_valid && alu_ready;
    assign head_entry = entries[head];

    always_comb begin
        in_rd   = alu_rd;
        in_data = alu_data;
        if (acc_mem) begin
            in_rd   = mem_rd;
            in_data = mem_data;
        end
    end

    // x0 results are handshaken but never stored.
    assign push = (acc_mem || acc_alu) && (in_rd != REG_ZERO);

`ifdef WBQ_BYPASS_EN
    assign bypass = push && empty && drain_en;
`else
    assign bypass = 1'b0;
`endif

    assign enqueue = push && !bypass;

    always_comb begin
        write_enable = pop || bypass;
        rd_address   = REG_ZERO;
        rd_data      = '0;
        if (pop) begin
            rd_address = head_entry.rd;
            rd_data    = head_entry.data;
        end else if (bypass) begin
            rd_address = in_rd;
            rd_data    = in_data;
        end
    end

    // Pop clears before push writes, so a full push+pop on the same slot keeps the new entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head <= PTR_W'(wrap_inc(32'(head), DEPTH));
            end
            if (enqueue) begin
                entries[tail] <= '{valid: 1'b1, rd: in_rd, data: in_data};
                tail <= PTR_W'(wrap_inc(32'(tail), DEPTH));
            end
            count <= count + (PTR_W+1)'(enqueue) - (PTR_W+1)'(pop);
        end
    end

    wbq_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd1 (
        .entries(entries), .head(head), .count(count),
        .address(rs1_address), .hit(q1_hit), .data(q1_data)
    );

    wbq_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd2 (
        .entries(entries), .head(head), .count(count),
        .address(rs2_address), .hit(q2_hit), .data(q2_data)
    );

    // A bypassing input only exists while the queue is empty, so it is the youngest match.
    assign rs1_fwd_hit  = q1_hit || (bypass && rs1_address == in_rd);
    assign rs1_fwd_data = (bypass && rs1_address == in_rd) ? in_data : q1_data;
    assign rs2_fwd_hit  = q2_hit || (bypass && rs2_address == in_rd);
    assign rs2_fwd_data = (bypass && rs2_address == in_rd) ? in_data : q2_data;

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed and randomized checks of wb_queue against a queue-based model
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock, reset_n;
    logic            alu_valid, alu_ready, mem_valid, mem_ready, drain_en;
    logic [4:0]      alu_rd, mem_rd, rd_address, rs1_address, rs2_address;
    logic [XLEN-1:0] alu_data, mem_data, rd_data, rs1_fwd_data, rs2_fwd_data;
    logic            write_enable, rs1_fwd_hit, rs2_fwd_hit;
    logic [2:0]      count;

    wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .drain_en(drain_en), .write_enable(write_enable), .rd_address(rd_address), .rd_data(rd_data),
        .rs1_address(rs1_address), .rs1_fwd_hit(rs1_fwd_hit), .rs1_fwd_data(rs1_fwd_data),
        .rs2_address(rs2_address), .rs2_fwd_hit(rs2_fwd_hit), .rs2_fwd_data(rs2_fwd_data),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

    wb_t q[$];
    int  tests = 0;
    int  fails = 0;
    logic m_pop, m_acc, m_acc_mem, m_acc_alu, m_byp;
    wb_t  m_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            foreach (q[i]) if (q[i].rd == a) begin h = 1'b1; d = q[i].data; end
            if (m_byp && m_in.rd == a) begin h = 1'b1; d = m_in.data; end
        end
    endfunction

    // Called at posedge+1: drive, check settled outputs, cross the edge, advance the model.
    task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic dr, input logic [4:0] r1, input logic [4:0] r2);
        logic space, h;
        logic [31:0] d;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        drain_en = dr; rs1_address = r1; rs2_address = r2;
        #3;
        m_pop     = (q.size() > 0) && dr;
        space     = (q.size() < DEPTH) || m_pop;
        m_acc_mem = mv && space;
        m_acc_alu = av && space && !mv;
        m_acc     = m_acc_mem || m_acc_alu;
        m_in.rd   = m_acc_mem ? mrd : ard;
        m_in.data = m_acc_mem ? md : ad;
        m_byp     = 1'b0;
`ifdef WBQ_BYPASS_EN
        m_byp = m_acc && m_in.rd != 5'd0 && q.size() == 0 && dr;
`endif
        chk("mem_ready", 32'(mem_ready), 32'(space));
        chk("alu_ready", 32'(alu_ready), 32'(space && !mv));
        chk("count", 32'(count), 32'(q.size()));
        chk("write_enable", 32'(write_enable), 32'(m_pop || m_byp));
        chk("rd_address", 32'(rd_address), m_pop ? 32'(q[0].rd) : m_byp ? 32'(m_in.rd) : 32'd0);
        chk("rd_data", rd_data, m_pop ? q[0].data : m_byp ? m_in.data : 32'd0);
        fwd(r1, h, d);
        chk("rs1_fwd_hit", 32'(rs1_fwd_hit), 32'(h));
        chk("rs1_fwd_data", rs1_fwd_data, d);
        fwd(r2, h, d);
        chk("rs2_fwd_hit", 32'(rs2_fwd_hit), 32'(h));
        chk("rs2_fwd_data", rs2_fwd_data, d);
        @(posedge clock);
        #1;
        if (m_pop) void'(q.pop_front());
        if (m_acc && m_in.rd != 5'd0 && !m_byp) q.push_back(m_in);
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, dr, 5'd0, 5'd0);
    endtask

    initial begin
        logic pm_v, pa_v;
        logic [4:0] pm_rd, pa_rd;
        logic [31:0] pm_d, pa_d;

        // Reset held with producers active.
        reset_n = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        drain_en = 1'b1; rs1_address = 5'd3; rs2_address = 5'd4;
        repeat (3) @(posedge clock);
        #1;
        mem_valid = 1'b0; alu_valid = 1'b0;
        reset_n = 1'b1;
        #3;
        chk("rst_write_enable", 32'(write_enable), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_rs1_hit", 32'(rs1_fwd_hit), 32'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset with three entries queued.
        step(1'b0, 5'd0, 0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 0, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 5'd0);
        alu_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // Ordering and one-cycle latency.
        step(1'b0, 5'd0, 0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 5'd0);
`ifndef WBQ_BYPASS_EN
        #3;
        chk("lat_first_we", 32'(write_enable), 32'd1);
        chk("lat_first_rd", 32'(rd_address), 32'd5);
        chk("lat_first_data", rd_data, 32'h11);
`endif
        step(1'b0, 5'd0, 0, 1'b1, 5'd6, 32'h22, 1'b1, 5'd6, 5'd5);
        idle(1'b1);
        idle(1'b1);

        // Arbitration: load unit wins, ALU waits one cycle.
        step(1'b1, 5'd7, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b0, 5'd7, 5'd8);
        step(1'b0, 5'd0, 0, 1'b1, 5'd8, 32'hBB, 1'b0, 5'd7, 5'd8);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Full boundary, push+pop while full, pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(11 + i), 32'(100 + i), 1'b0, 5'd0, 0, 1'b0, 5'd12, 5'd0);
        #3;
        chk("full_count", 32'(count), 32'd4);
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        step(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h201, 1'b0, 5'd11, 5'd20);
        step(1'b1, 5'd20, 32'h200, 1'b0, 5'd0, 0, 1'b1, 5'd11, 5'd20);
        step(1'b0, 5'd0, 0, 1'b1, 5'd21, 32'h201, 1'b1, 5'd20, 5'd21);
        repeat (6) idle(1'b1);

        // Forwarding: youngest match wins, x0 never hits.
        step(1'b0, 5'd0, 0, 1'b1, 5'd9, 32'd1, 1'b0, 5'd9, 5'd0);
        step(1'b1, 5'd10, 32'd2, 1'b0, 5'd0, 0, 1'b0, 5'd9, 5'd10);
        step(1'b0, 5'd0, 0, 1'b1, 5'd9, 32'd3, 1'b0, 5'd9, 5'd0);
        idle(1'b0);
        rs1_address = 5'd9; rs2_address = 5'd0;
        #3;
        chk("fwd_rs1_hit", 32'(rs1_fwd_hit), 32'd1);
        chk("fwd_rs1_data", rs1_fwd_data, 32'd3);
        chk("fwd_rs2_hit", 32'(rs2_fwd_hit), 32'd0);
        @(posedge clock);
        #1;
        repeat (4) step(1'b0, 5'd0, 0, 1'b0, 5'd0, 0, 1'b1, 5'd9, 5'd10);

        // x0 drop, then bypass (or normal latency) into an empty queue.
        step(1'b0, 5'd0, 0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 5'd0);
        #3;
        chk("x0_count", 32'(count), 32'd0);
        chk("x0_no_write", 32'(write_enable), 32'd0);
        @(posedge clock);
        #1;
`ifdef WBQ_BYPASS_EN
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44; drain_en = 1'b1;
        #3;
        chk("byp_we", 32'(write_enable), 32'd1);
        chk("byp_rd", 32'(rd_address), 32'd4);
        chk("byp_data", rd_data, 32'h44);
        @(posedge clock);
        #1;
        mem_valid = 1'b0;
        #3;
        chk("byp_count", 32'(count), 32'd0);
        @(posedge clock);
        #1;
`else
        step(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 0, 1'b1, 5'd4, 5'd0);
        idle(1'b1);
`endif

        // Randomized traffic; producers hold rd/data until accepted.
        pm_v = 1'b0; pa_v = 1'b0;
        pm_rd = '0; pa_rd = '0; pm_d = '0; pa_d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pm_v) begin
                pm_v = ($urandom_range(0, 9) < 5); pm_rd = 5'($urandom_range(0, 7)); pm_d = $urandom;
            end
            if (!pa_v) begin
                pa_v = ($urandom_range(0, 9) < 6); pa_rd = 5'($urandom_range(0, 7)); pa_d = $urandom;
            end
            step(pm_v, pm_rd, pm_d, pa_v, pa_rd, pa_d, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (m_acc_mem) pm_v = 1'b0;
            if (m_acc_alu) pa_v = 1'b0;
        end
        repeat (DEPTH + 1) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback queue that serves as the single writer for the register file's write port (write_enable / rd_address / rd_data).
- Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes, and buffers them in order.
- Drains the buffer into the register file one entry per cycle whenever drain_en is high.
- Provides forwarding lookups for rs1 and rs2, so decode sees values that are still queued but not yet written.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- XLEN, 32, data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  queue accepts the ALU result.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load result valid.
- mem_ready  output  1  queue accepts the load result.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load result.
- drain_en  input  1  register file write port available this cycle.
- write_enable  output  1  register file write strobe.
- rd_address  output  5  register file write address.
- rd_data  output  XLEN  register file write data.
- rs1_address  input  5  forwarding lookup address, port 1.
- rs1_fwd_hit  output  1  a pending write to rs1 exists.
- rs1_fwd_data  output  XLEN  youngest pending data for rs1.
- rs2_address  input  5  forwarding lookup address, port 2.
- rs2_fwd_hit  output  1  a pending write to rs2 exists.
- rs2_fwd_data  output  XLEN  youngest pending data for rs2.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of wb_entry_t with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a separate count register.
  - empty = (count==0); full = (count==DEPTH).
- Reset, asynchronous and active-low:
  - count=0, pointers=0, all entry valid bits cleared.
  - While empty: write_enable=0, rd_address=0, rd_data=0, both fwd_hit=0, both fwd_data=0.
  - alu_ready=1 and mem_ready=1 once reset_n is high.
  - Reset asserted mid-operation discards every queued entry; nothing is written to the register file.
- Pop: pop = !empty && drain_en.
  - write_enable = pop.
  - rd_address and rd_data come from the head entry, gated to 0 when !pop. The outputs are combinational from registered state.
- Space: space = !full || pop. A full queue that is popping in the same cycle still accepts one entry.
- Arbitration: at most one enqueue per cycle, and the load unit has fixed priority.
  - mem_ready = space.
  - alu_ready = space && !mem_valid.
- x0 filter: a result with rd==0 is accepted, meaning ready is asserted as above, but it is dropped.
  - It is not enqueued and count does not change.
  - x0 writes are never emitted on the write port.
- Latency: an entry accepted at edge N is present at the head in cycle N+1 if the queue was empty. It is written at the end of the first cycle in which it is at the head and drain_en=1.
- Simultaneous push and pop: count is unchanged; head and tail both advance.
- Ordering: strict FIFO; entries write in acceptance order.
  - Two queued writes to the same rd both reach the register file, older first.
- Forwarding: for each lookup port, scan valid entries and report the youngest entry whose rd equals the lookup address.
  - "Youngest" means closest to the tail, including the head that is being written this cycle.
  - An address of 0 never hits.
  - Lookup is purely combinational and does not see an input that is being accepted in the same cycle.
- Overflow and underflow cannot occur: ready deasserts when there is no space, and pop requires !empty.
  - A producer that holds valid while ready=0 must keep rd and data stable; the queue samples them only on acceptance.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- With the macro defined: when the queue is empty, drain_en=1, and an input is accepted with rd!=0, that input drives write_enable, rd_address and rd_data combinationally in the same cycle.
  - The entry is not enqueued, giving 0-cycle latency.
  - The forwarding ports also hit on this bypassing input.
- Without the macro: the 1-cycle minimum latency described above applies, and the write port never depends combinationally on the producer inputs.

Decomposition:
- Package wbq_pkg:
  - typedef wb_entry_t {logic valid; logic [4:0] rd; logic [XLEN-1:0] data}.
  - Localparam REG_ZERO=5'd0.
  - Function for the pointer-increment wrap.
- Sub-module wbq_fwd_lookup:
  - Inputs: entry array, head pointer, count, lookup address.
  - Outputs: hit and data.
  - Implements the youngest-match priority scan.
  - Instantiated once each for rs1 and rs2.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with producers active, then release → write_enable=0, count=0, alu_ready=1, mem_ready=1. Assert reset_n=0 again with 3 entries queued → count=0 immediately (asynchronous), no writes follow.
- Ordering and latency: with drain_en=1, push ALU {x5, 0x11}, then ALU {x6, 0x22} on the next cycle → write_enable=1 with x5/0x11 one cycle after the first accept, then x6/0x22; count returns to 0.
- Arbitration: alu_valid and mem_valid both high, mem {x7, 0xAA}, alu {x8, 0xBB} → alu_ready=0, x7 accepted; x8 accepted the following cycle; writes occur in the order x7, x8.
- Full boundary: drain_en=0, push DEPTH entries → count=4 and both ready signals 0. Raise drain_en with a push pending → push and pop in the same cycle, count stays 4; the head is written, and the pointers wrap past entry 3.
- Forwarding: drain_en=0, queue {x9, 1}, {x10, 2}, {x9, 3}; set rs1=x9, rs2=x0 → rs1_fwd_hit=1, rs1_fwd_data=3, rs2_fwd_hit=0.
- x0 drop and bypass: push ALU {x0, 0xFF} → no write and count=0. Under WBQ_BYPASS_EN, push {x4, 0x44} into an empty queue with drain_en=1 → write_enable=1 with x4/0x44 in the same cycle, and count stays 0.
